// File: rtl/ray_march_ctrl_pkg.sv
// Shared fixed-point vector package for the ray marcher: Q16.16 scalar type,
// 3-component vector, multiply / saturating add helpers and the march FSM states.
// Build option consumed by ray_march_ctrl: RAY_MARCH_TIMEOUT_EN (SDF response timeout).
package ray_march_ctrl_pkg;

  localparam int FP_W    = 32;
  localparam int FP_FRAC = 16;

  typedef logic signed [FP_W-1:0] fp_t;

  typedef struct packed {
    fp_t x;
    fp_t y;
    fp_t z;
  } vec3_t;

  localparam fp_t FP_ZERO = 32'sh0000_0000;
  localparam fp_t FP_ONE  = 32'sh0001_0000;
  localparam fp_t FP_MAX  = 32'sh7FFF_FFFF;
  localparam fp_t FP_MIN  = 32'sh8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } march_state_e;

  // Q16.16 multiply; the discarded fraction bits truncate toward -infinity.
  function automatic fp_t fp_mul(input fp_t a, input fp_t b);
    logic signed [2*FP_W-1:0] a_w;
    logic signed [2*FP_W-1:0] b_w;
    logic signed [2*FP_W-1:0] prod;
    a_w  = {{FP_W{a[FP_W-1]}}, a};
    b_w  = {{FP_W{b[FP_W-1]}}, b};
    prod = a_w * b_w;
    return prod[FP_FRAC +: FP_W];
  endfunction

  // Q16.16 add that clamps to the most positive / most negative value on overflow.
  function automatic fp_t fp_add_sat(input fp_t a, input fp_t b);
    logic [FP_W:0] sum;
    sum = {a[FP_W-1], a} + {b[FP_W-1], b};
    if (sum[FP_W] != sum[FP_W-1]) begin
      return sum[FP_W] ? FP_MIN : FP_MAX;
    end
    return sum[FP_W-1:0];
  endfunction

endpackage

// File: rtl/ray_march_ctrl_point_gen.sv
// ray_point_gen: registers the march sample point origin + t*dir when enabled.
// The point holds its value while en is low so the evaluator sees a stable sample.
module ray_point_gen
  import ray_march_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  vec3_t origin,
  input  vec3_t dir,
  input  fp_t   t,
  output vec3_t point
);

  logic [2:0][FP_W-1:0] origin_c;
  logic [2:0][FP_W-1:0] dir_c;
  logic [2:0][FP_W-1:0] sum_c;
  vec3_t                point_reg;

  assign origin_c = origin;
  assign dir_c    = dir;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      assign sum_c[gi] = fp_add_sat(fp_t'(origin_c[gi]), fp_mul(t, fp_t'(dir_c[gi])));
    end
  endgenerate

  // Capture the new sample point only on the issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      point_reg <= '0;
    end else if (en) begin
      point_reg <= vec3_t'(sum_c);
    end
  end

  assign point = point_reg;

endmodule

// File: rtl/ray_march_ctrl.sv
// ray_march_ctrl: sphere-tracing controller. Accepts a ray, repeatedly issues
// sample points to an external SDF evaluator, advances t by the returned distance
// and reports hit / miss with the final t, position and step count.
// Build option: RAY_MARCH_TIMEOUT_EN adds a bounded wait for each SDF response.
module ray_march_ctrl
  import ray_march_ctrl_pkg::*;
#(
  parameter int  MAX_STEPS   = 64,
  parameter fp_t HIT_EPS     = 32'sh0000_0100,
  parameter fp_t MAX_DIST    = 32'sh0040_0000,
  parameter int  SDF_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ray_valid,
  output logic                           ray_ready,
  input  vec3_t                          ray_origin,
  input  vec3_t                          ray_dir,
  output vec3_t                          point,
  output logic                           point_valid,
  input  fp_t                            sdf_dist,
  input  logic                           sdf_valid,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           res_hit,
  output fp_t                            res_t,
  output vec3_t                          res_pos,
  output logic [$clog2(MAX_STEPS+1)-1:0] res_steps,
  output logic                           res_timeout
);

  localparam int                STEP_W     = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  march_state_e      state_reg;
  march_state_e      state_next;
  vec3_t             origin_reg;
  vec3_t             dir_reg;
  fp_t               t_reg;
  fp_t               sdf_reg;
  logic [STEP_W-1:0] steps_reg;
  logic              point_valid_reg;
  logic              res_hit_reg;
  fp_t               res_t_reg;
  vec3_t             res_pos_reg;
  logic [STEP_W-1:0] res_steps_reg;

  fp_t  t_adv;
  logic hit_now;
  logic stop_now;
  logic finish_now;
  logic timeout_now;

  // Decision terms for the update cycle: negative distances count as inside the surface.
  assign t_adv      = fp_add_sat(t_reg, sdf_reg);
  assign hit_now    = (sdf_reg < HIT_EPS);
  assign stop_now   = (t_adv > MAX_DIST) || (steps_reg == STEP_LIMIT);
  assign finish_now = (state_reg == ST_UPDATE) && (hit_now || stop_now);

`ifdef RAY_MARCH_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(SDF_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SDF_TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             res_timeout_reg;

  // Count cycles spent in WAIT; restarts each time WAIT is entered.
  always_ff @(posedge clk) begin
    if (rst || (state_reg != ST_WAIT)) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
    end
  end

  assign timeout_now = (state_reg == ST_WAIT) && !sdf_valid && (wait_cnt_reg == CNT_LAST);

  // Timeout flag is set only by an abandoned wait and cleared by a normal finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_timeout_reg <= 1'b0;
    end else if (timeout_now) begin
      res_timeout_reg <= 1'b1;
    end else if (finish_now) begin
      res_timeout_reg <= 1'b0;
    end
  end

  assign res_timeout = res_timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (SDF_TIMEOUT > 0);
  assign timeout_now        = 1'b0;
  assign res_timeout        = 1'b0;
`endif

  // Next-state selection for the march loop.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (ray_valid) state_next = ST_ISSUE;
      ST_ISSUE:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (sdf_valid) begin
          state_next = ST_UPDATE;
        end else if (timeout_now) begin
          state_next = ST_DONE;
        end
      end
      ST_UPDATE: state_next = (hit_now || stop_now) ? ST_DONE : ST_ISSUE;
      ST_DONE:   if (res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Per-ray working registers: latched ray, march distance, step count, last SDF sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      origin_reg      <= '0;
      dir_reg         <= '0;
      t_reg           <= FP_ZERO;
      sdf_reg         <= FP_ZERO;
      steps_reg       <= '0;
      point_valid_reg <= 1'b0;
    end else begin
      point_valid_reg <= (state_reg == ST_ISSUE);
      case (state_reg)
        ST_IDLE: begin
          if (ray_valid) begin
            origin_reg <= ray_origin;
            dir_reg    <= ray_dir;
            t_reg      <= FP_ZERO;
            steps_reg  <= '0;
          end
        end
        ST_WAIT: begin
          if (sdf_valid) begin
            sdf_reg   <= sdf_dist;
            steps_reg <= steps_reg + STEP_W'(1);
          end
        end
        ST_UPDATE: begin
          if (!hit_now && !stop_now) begin
            t_reg <= t_adv;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers are written only on the transition into DONE and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_hit_reg   <= 1'b0;
      res_t_reg     <= FP_ZERO;
      res_pos_reg   <= '0;
      res_steps_reg <= '0;
    end else if (finish_now) begin
      res_hit_reg   <= hit_now;
      res_t_reg     <= hit_now ? t_reg : t_adv;
      res_pos_reg   <= point;
      res_steps_reg <= steps_reg;
    end else if (timeout_now) begin
      res_hit_reg   <= 1'b0;
      res_t_reg     <= t_reg;
      res_pos_reg   <= point;
      res_steps_reg <= steps_reg;
    end
  end

  ray_point_gen u_point_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (state_reg == ST_ISSUE),
    .origin (origin_reg),
    .dir    (dir_reg),
    .t      (t_reg),
    .point  (point)
  );

  assign ray_ready   = (state_reg == ST_IDLE);
  assign point_valid = point_valid_reg;
  assign res_valid   = (state_reg == ST_DONE);
  assign res_hit     = res_hit_reg;
  assign res_t       = res_t_reg;
  assign res_pos     = res_pos_reg;
  assign res_steps   = res_steps_reg;

endmodule
